// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounces mode/inc/dec buttons and walks an edit
// sequence hour -> minute -> second, pulsing load_o when the edit is committed.
module time_set_ctrl #(
  parameter int DB_CYCLES    = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int TIMEOUT      = 10000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  input  logic       dec_btn_i,
  input  logic [4:0] cur_hour_i,
  input  logic [5:0] cur_min_i,
  input  logic [5:0] cur_sec_i,
  output logic [4:0] hour_set_o,
  output logic [5:0] min_set_o,
  output logic [5:0] sec_set_o,
  output logic       load_o,
  output logic [1:0] field_o
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_DELAY + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam int BTN_MODE = 0;
  localparam int BTN_INC  = 1;
  localparam int BTN_DEC  = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_e;

  logic [2:0]      raw_btn;
  logic [2:0]      sync1_q, sync2_q, db_q, db_dly_q;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [2:0]      press;

  logic [RP_W-1:0] rpt_cnt_q;
  logic            held_one, rpt, rpt_inc, rpt_dec;
  logic            inc_ev, dec_ev, any_ev, step_up, step_dn;

  state_e          state_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [4:0]      hour_q;
  logic [5:0]      min_q, sec_q;
  logic            load_q;

  assign raw_btn = {dec_btn_i, inc_btn_i, mode_btn_i};

  // A debounced level only flips once the synchronized level has disagreed
  // with it for DB_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      for (int b = 0; b < 3; b++) db_cnt_q[b] <= '0;
    end else begin
      sync1_q  <= raw_btn;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      for (int b = 0; b < 3; b++) begin
        if (sync2_q[b] == db_q[b]) begin
          db_cnt_q[b] <= '0;
        end else if (db_cnt_q[b] == DB_W'(DB_CYCLES - 1)) begin
          db_q[b]     <= sync2_q[b];
          db_cnt_q[b] <= '0;
        end else begin
          db_cnt_q[b] <= db_cnt_q[b] + DB_W'(1);
        end
      end
    end
  end

  assign press = db_q & ~db_dly_q;

  // rpt_cnt_q counts cycles since the inc/dec press; zero means "not armed",
  // so holding both buttons (or releasing) disarms repeat until a new press.
  assign held_one = db_q[BTN_INC] ^ db_q[BTN_DEC];
  assign rpt      = held_one && (rpt_cnt_q == RP_W'(REPEAT_DELAY));
  assign rpt_inc  = rpt & db_q[BTN_INC];
  assign rpt_dec  = rpt & db_q[BTN_DEC];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rpt_cnt_q <= '0;
    end else if (press[BTN_INC] || press[BTN_DEC]) begin
      rpt_cnt_q <= RP_W'(1);
    end else if (!held_one) begin
      rpt_cnt_q <= '0;
    end else if (rpt) begin
      rpt_cnt_q <= RP_W'(REPEAT_DELAY - REPEAT_RATE + 1);
    end else if (rpt_cnt_q != '0) begin
      rpt_cnt_q <= rpt_cnt_q + RP_W'(1);
    end
  end

  assign inc_ev  = press[BTN_INC] | rpt_inc;
  assign dec_ev  = press[BTN_DEC] | rpt_dec;
  assign step_up = inc_ev & ~dec_ev;
  assign step_dn = dec_ev & ~inc_ev;
  assign any_ev  = (|press) | rpt;

  function automatic logic [5:0] step6(input logic [5:0] v, input logic [5:0] max_v,
                                       input logic up);
    logic [5:0] r;
    if (up) r = (v >= max_v) ? 6'd0 : v + 6'd1;
    else    r = (v == 6'd0 || v > max_v) ? max_v : v - 6'd1;
    return r;
  endfunction

  // load_o is a bare one-cycle strobe with no back-pressure: the timekeeper
  // must sample *_set_o on the cycle load_o is high.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      load_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (state_q == IDLE) begin
        to_cnt_q <= '0;
        if (press[BTN_MODE]) begin
          state_q <= SET_HOUR;
          hour_q  <= (cur_hour_i > 5'd23) ? 5'd0 : cur_hour_i;
          min_q   <= (cur_min_i > 6'd59) ? 6'd0 : cur_min_i;
          sec_q   <= (cur_sec_i > 6'd59) ? 6'd0 : cur_sec_i;
        end
      end else if (press[BTN_MODE]) begin
        to_cnt_q <= '0;
        case (state_q)
          SET_HOUR: state_q <= SET_MIN;
          SET_MIN:  state_q <= SET_SEC;
          default: begin
            state_q <= IDLE;
            load_q  <= 1'b1;
          end
        endcase
      end else if (any_ev) begin
        to_cnt_q <= '0;
        if (step_up || step_dn) begin
          case (state_q)
            SET_HOUR: hour_q <= 5'(step6({1'b0, hour_q}, 6'd23, step_up));
            SET_MIN:  min_q  <= step6(min_q, 6'd59, step_up);
            default:  sec_q  <= step6(sec_q, 6'd59, step_up);
          endcase
        end
      end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
        state_q  <= IDLE;
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end

  assign hour_set_o = hour_q;
  assign min_set_o  = min_q;
  assign sec_set_o  = sec_q;
  assign load_o     = load_q;
  assign field_o    = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized bench for time_set_ctrl: a time-setting model predicts every
// output change; a negedge monitor pops and compares each change it sees.
module tb_time_set_ctrl;

  localparam int DB = 20;
  localparam int RD = 500;
  localparam int RR = 100;
  localparam int TO = 10000;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic       mode_btn_i = 1'b0, inc_btn_i = 1'b0, dec_btn_i = 1'b0;
  logic [4:0] cur_hour_i = '0;
  logic [5:0] cur_min_i = '0, cur_sec_i = '0;
  logic [4:0] hour_set_o;
  logic [5:0] min_set_o, sec_set_o;
  logic       load_o;
  logic [1:0] field_o;

  time_set_ctrl #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .mode_btn_i(mode_btn_i), .inc_btn_i(inc_btn_i), .dec_btn_i(dec_btn_i),
    .cur_hour_i(cur_hour_i), .cur_min_i(cur_min_i), .cur_sec_i(cur_sec_i),
    .hour_set_o(hour_set_o), .min_set_o(min_set_o), .sec_set_o(sec_set_o),
    .load_o(load_o), .field_o(field_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [19:0] exp_q[$];
  logic [19:0] last_exp = '0;
  int          m_field = 0, m_h = 0, m_m = 0, m_s = 0;
  int          m_loads = 0;
  int          load_cycles = 0;

  function automatic logic [19:0] pack(int ld, int f, int h, int m, int s);
    return {ld[0], f[1:0], h[4:0], m[5:0], s[5:0]};
  endfunction

  function automatic void push_model(int ld);
    logic [19:0] t;
    t = pack(ld, m_field, m_h, m_m, m_s);
    if (t != last_exp) begin
      exp_q.push_back(t);
      last_exp = t;
    end
  endfunction

  function automatic void model_mode();
    if (m_field == 0) begin
      m_field = 1;
      m_h = int'(cur_hour_i);
      m_m = int'(cur_min_i);
      m_s = int'(cur_sec_i);
      push_model(0);
    end else if (m_field == 3) begin
      m_field = 0;
      m_loads++;
      push_model(1);
      push_model(0);
    end else begin
      m_field++;
      push_model(0);
    end
  endfunction

  function automatic void model_step(bit up);
    if (m_field == 0) return;
    case (m_field)
      1:       m_h = up ? (m_h + 1) % 24 : (m_h + 23) % 24;
      2:       m_m = up ? (m_m + 1) % 60 : (m_m + 59) % 60;
      default: m_s = up ? (m_s + 1) % 60 : (m_s + 59) % 60;
    endcase
    push_model(0);
  endfunction

  // Auto-repeat steps for a debounced hold of `hold` cycles.
  function automatic int n_repeats(int hold);
    if (hold <= RD) return 0;
    return (hold - RD - 1) / RR + 1;
  endfunction

  function automatic void model_timeout();
    if (m_field != 0) begin
      m_field = 0;
      push_model(0);
    end
  endfunction

  function automatic void model_reset();
    m_field = 0; m_h = 0; m_m = 0; m_s = 0;
    push_model(0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mask bits: [0] mode, [1] inc, [2] dec
  task automatic press(logic [2:0] mask, int hold);
    if (mask[0]) model_mode();
    else if (mask[1] ^ mask[2])
      for (int i = 0; i < 1 + n_repeats(hold); i++) model_step(mask[1]);
    {dec_btn_i, inc_btn_i, mode_btn_i} = mask;
    tick(hold);
    {dec_btn_i, inc_btn_i, mode_btn_i} = 3'b000;
    tick(DB + 10);
  endtask

  task automatic glitch(logic [2:0] mask, int len);
    {dec_btn_i, inc_btn_i, mode_btn_i} = mask;
    tick(len);
    {dec_btn_i, inc_btn_i, mode_btn_i} = 3'b000;
    tick(DB + 10);
  endtask

  task automatic set_cur(int h, int m, int s);
    cur_hour_i = 5'(h);
    cur_min_i  = 6'(m);
    cur_sec_i  = 6'(s);
  endtask

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [19:0] prev, cur, e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {load_o, field_o, hour_set_o, min_set_o, sec_set_o};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_seq: unexpected change to ld=%0d f=%0d %0d:%0d:%0d",
                   cur[19], cur[18:17], cur[16:12], cur[11:6], cur[5:0]);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL out_seq: got ld=%0d f=%0d %0d:%0d:%0d expected ld=%0d f=%0d %0d:%0d:%0d",
                     cur[19], cur[18:17], cur[16:12], cur[11:6], cur[5:0],
                     e[19], e[18:17], e[16:12], e[11:6], e[5:0]);
          end
        end
        prev = cur;
      end
    end
  end

  always @(negedge clk) if (load_o === 1'b1) load_cycles++;

  // ---------------- stimulus ----------------
  initial begin
    int lat, r, k;
    tick(3);
    check("reset_field", field_o, 0);
    check("reset_load", load_o, 0);
    check("reset_set", {hour_set_o, min_set_o, sec_set_o}, 0);
    reset_i = 1'b1;
    tick(5);

    // capture 13:45:07, then wrap the hour through 23 -> 0
    set_cur(13, 45, 7);
    press(3'b001, 30);
    check("capture_field", field_o, 1);
    check("capture_hour", hour_set_o, 13);
    check("capture_min", min_set_o, 45);
    check("capture_sec", sec_set_o, 7);
    repeat (11) press(3'b010, 30);
    check("hour_wrap_up", hour_set_o, 0);
    check("hour_wrap_field", field_o, 1);
    repeat (3) press(3'b001, 30);
    check("commit_field", field_o, 0);
    check("commit_hold", {hour_set_o, min_set_o, sec_set_o}, {5'd0, 6'd45, 6'd7});

    // full walk with min 0 -> 59 and sec 59 -> 0
    set_cur(5, 0, 59);
    press(3'b001, 30);
    press(3'b001, 30);
    press(3'b100, 30);
    check("min_wrap_down", min_set_o, 59);
    press(3'b001, 30);
    press(3'b010, 30);
    check("sec_wrap_up", sec_set_o, 0);
    press(3'b001, 30);
    check("walk_idle", field_o, 0);
    tick(50);
    check("walk_hold", {hour_set_o, min_set_o, sec_set_o}, {5'd5, 6'd59, 6'd0});

    // auto-repeat in SET_MIN
    set_cur(9, 10, 30);
    press(3'b001, 30);
    press(3'b001, 30);
    press(3'b010, 1200);
    check("repeat_inc_1200", min_set_o, 18);
    press(3'b100, RD + 2 * RR + 50);
    check("repeat_dec", min_set_o, 14);

    // glitch and coincident presses
    glitch(3'b010, DB - 1);
    check("glitch_ignored", min_set_o, 14);
    press(3'b110, 40);
    check("inc_dec_ignored", min_set_o, 14);
    press(3'b011, 40);
    check("mode_wins_field", field_o, 3);
    check("mode_wins_sec", sec_set_o, 30);

    // randomized sequence
    for (int i = 0; i < 60; i++) begin
      if (m_field == 0)
        set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      r = $urandom_range(0, 15);
      if (r <= 3)       press(3'b001, $urandom_range(DB + 5, 300));
      else if (r <= 7)  press(3'b010, $urandom_range(DB + 5, 300));
      else if (r <= 11) press(3'b100, $urandom_range(DB + 5, 300));
      else if (r == 12) press(3'b110, $urandom_range(DB + 5, 300));
      else if (r == 13) press($urandom_range(0, 1) ? 3'b011 : 3'b101, $urandom_range(DB + 5, 300));
      else if (r == 14) glitch(3'b001 << $urandom_range(0, 2), $urandom_range(1, DB - 1));
      else begin
        k = $urandom_range(0, 3);
        press($urandom_range(0, 1) ? 3'b010 : 3'b100, RD + k * RR + $urandom_range(30, 70));
      end
    end

    // inactivity timeout
    if (m_field != 0) begin
      model_timeout();
      tick(TO + 200);
    end
    check("pre_timeout_idle", field_o, 0);
    set_cur(21, 33, 44);
    press(3'b001, 30);
    check("timeout_enter", field_o, 1);
    tick(TO - 300);
    check("timeout_not_early", field_o, 1);
    model_timeout();
    tick(500);
    check("timeout_field", field_o, 0);
    check("timeout_hold", {hour_set_o, min_set_o, sec_set_o}, {5'd21, 6'd33, 6'd44});

    // reset mid-edit, then mode held through reset release
    set_cur(7, 8, 9);
    press(3'b001, 30);
    press(3'b001, 30);
    check("pre_reset_field", field_o, 2);
    @(posedge clk);
    #3;
    model_reset();
    reset_i = 1'b0;
    #1;
    check("async_reset_field", field_o, 0);
    check("async_reset_load", load_o, 0);
    check("async_reset_set", {hour_set_o, min_set_o, sec_set_o}, 0);
    mode_btn_i = 1'b1;
    tick(3);
    set_cur(17, 2, 3);
    model_mode();
    reset_i = 1'b1;
    lat = 0;
    while (field_o != 2'd1 && lat < 100) begin
      tick(1);
      lat++;
    end
    checks++;
    if (lat < DB || lat > DB + 4) begin
      errors++;
      $display("FAIL post_reset_latency: got %0d cycles expected %0d..%0d", lat, DB, DB + 4);
    end
    mode_btn_i = 1'b0;
    tick(DB + 10);
    check("post_reset_hour", hour_set_o, 17);

    tick(20);
    check("exp_queue_drained", exp_q.size(), 0);
    check("load_pulse_cycles", load_cycles, m_loads);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameters SHALL be:
  DB_CYCLES     20   cycles a button level must be stable to count as debounced
  REPEAT_DELAY  500  cycles inc/dec must be held before auto-repeat starts
  REPEAT_RATE   100  cycles between auto-repeat steps
  TIMEOUT       10000  idle cycles in an edit state before the edit is aborted
REQ-002 Ports SHALL be:
  clk_i        in   1  single clock (1 kHz system tick); all logic on rising edge
  reset_i      in   1  asynchronous, active-low reset
  mode_btn_i   in   1  raw mode button, active-high, asynchronous
  inc_btn_i    in   1  raw increment button, active-high, asynchronous
  dec_btn_i    in   1  raw decrement button, active-high, asynchronous
  cur_hour_i   in   5  live hour from timekeeper, 0..23
  cur_min_i    in   6  live minute, 0..59
  cur_sec_i    in   6  live second, 0..59
  hour_set_o   out  5  hour value to load into timekeeper
  min_set_o    out  6  minute value to load
  sec_set_o    out  6  second value to load
  load_o       out  1  one-cycle pulse: timekeeper loads *_set_o
  field_o      out  2  0 idle, 1 hour, 2 minute, 3 second (display blink select)

Function
REQ-003 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose output changes only after the synchronized level has held the new value for DB_CYCLES consecutive cycles.
REQ-004 A press event SHALL be a single-cycle pulse on the debounced rising edge; latency from raw edge to press event SHALL be fixed and no more than DB_CYCLES+4 cycles.
REQ-005 Glitches shorter than DB_CYCLES cycles SHALL produce no event.
REQ-006 FSM states SHALL be IDLE, SET_HOUR, SET_MIN, SET_SEC; field_o SHALL encode state per REQ-002.
REQ-007 IDLE + mode event -> SET_HOUR; hour/min/sec set registers SHALL capture cur_*_i on that same edge.
REQ-008 SET_HOUR + mode -> SET_MIN; SET_MIN + mode -> SET_SEC; SET_SEC + mode -> IDLE with load_o = 1 for exactly that one transition cycle.
REQ-009 Inc/dec events in IDLE SHALL be ignored.
REQ-010 Inc in an edit state SHALL add 1 to the selected field, wrapping hour 23->0, min/sec 59->0; dec SHALL subtract 1, wrapping hour 0->23, min/sec 0->59.
REQ-011 Inc and dec events in the same cycle SHALL both be ignored; mode coincident with inc/dec SHALL be acted on and inc/dec ignored.
REQ-012 Inc/dec held debounced-high for REPEAT_DELAY cycles after its press event SHALL generate a repeat step, then one every REPEAT_RATE cycles until release; holding both suppresses repeat.
REQ-013 An edit-state inactivity counter SHALL reset on any press or repeat event; reaching TIMEOUT SHALL return to IDLE with no load_o pulse.
REQ-014 *_set_o SHALL hold their value in IDLE (last loaded or captured) and never exceed 23/59/59.
REQ-015 load_o SHALL never assert outside the SET_SEC->IDLE transition.

Reset
REQ-016 reset_i low SHALL immediately force: state IDLE, field_o 0, load_o 0, *_set_o 0, synchronizers/debouncers/repeat and timeout counters 0.
REQ-017 Reset mid-edit SHALL discard the edit with no load_o pulse; a button held through reset release SHALL produce a press event only after full debounce.

Verification
REQ-018 Mode press with cur=13:45:07 -> field_o 1, set=13:45:07; inc x11 -> hour_set_o 0 (wrap 23->0), field_o stays 1.
REQ-019 Full walk: mode, mode, dec on min 0 -> 59, mode, inc on sec 59 -> 0, mode -> load_o single 1-cycle pulse, field_o 0, outputs hold.
REQ-020 Inc held 1200 cycles in SET_MIN from 10 -> min_set_o = 10+1+7 = 18 (press + repeats at 500,600,...,1100).
REQ-021 Raw inc glitch of DB_CYCLES-1 cycles -> no change; inc and dec pressed same cycle -> no change.
REQ-022 Enter SET_HOUR, no buttons for TIMEOUT cycles -> field_o 0, load_o never asserted.
REQ-023 Assert reset_i low during SET_MIN -> all outputs 0 asynchronously; release with mode held -> SET_HOUR entered only after debounce latency.
